// File: rtl/usr_pkg.sv
// Shared constants for the command sequencer: opcodes, slice mode encodings,
// FSM state encoding and the default register width.
package usr_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Right-moving ops drive the MSB serial input, left-moving ops the LSB one.
  function automatic logic [1:0] shift_mode(input logic [2:0] op);
    return ((op == OP_SHR) || (op == OP_ROR)) ? S_SHR : S_SHL;
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// 4-bit loadable down-counter that paces the shift phase; zero_o flags the
// last active shift cycle.
module usr_shift_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/usr_cmd_seq.sv
// Command sequencer translating LOAD/CLR/shift/rotate commands into per-cycle
// mode, parallel data and serial inputs for an external bit-slice register.
module usr_cmd_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] q_in,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] p_out,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q;
  logic [2:0]       op_q;
  logic             fill_q;
  logic [1:0]       s_q;
  logic [WIDTH-1:0] p_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             accept;
  logic             cnt_load;
  logic             cnt_zero;
  logic             unused_q_in;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_load  = accept && is_shift(cmd_op) && (cmd_cnt != 4'd0);

  // Loaded with cnt-1 so the zero flag marks the final shift cycle.
  usr_shift_counter u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (state_q == ST_SHIFT),
    .val_i  (cmd_cnt - 4'd1),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      fill_q  <= 1'b0;
      s_q     <= S_HOLD;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            fill_q <= cmd_fill;
            busy_q <= 1'b1;
            if ((cmd_op == OP_LOAD) || (cmd_op == OP_CLR)) begin
              state_q <= ST_LOAD;
              s_q     <= S_LOAD;
              p_q     <= (cmd_op == OP_LOAD) ? cmd_data : '0;
            end else if (cnt_load) begin
              state_q <= ST_SHIFT;
              s_q     <= shift_mode(cmd_op);
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= (cmd_op == OP_ILL);
            end
          end
        end
        ST_LOAD: begin
          state_q <= ST_DONE;
          s_q     <= S_HOLD;
          p_q     <= '0;
          done_q  <= 1'b1;
        end
        ST_SHIFT: begin
          if (cnt_zero) begin
            state_q <= ST_DONE;
            s_q     <= S_HOLD;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          s_q     <= S_HOLD;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Rotate feedback comes straight from the live register contents.
  always_comb begin
    sr_out = 1'b0;
    sl_out = 1'b0;
    if (state_q == ST_SHIFT) begin
      case (op_q)
        OP_SHR, OP_SHL: begin
          sr_out = fill_q;
          sl_out = fill_q;
        end
        OP_ROR:  sr_out = q_in[0];
        OP_ROL:  sl_out = q_in[WIDTH-1];
        default: ;
      endcase
    end
  end

  assign unused_q_in = ^q_in;

  assign s     = s_q;
  assign p_out = p_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_usr_cmd_seq.sv
// Randomized self-checking bench: a 4-bit slice register shares clk/rst with
// the sequencer, and a command-level model predicts every cycle's outputs.
module tb_usr_cmd_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [3:0]   cmd_cnt = 4'd0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_fill = 1'b0;
  logic [W-1:0] q_in;
  logic [1:0]   s;
  logic [W-1:0] p_out;
  logic         sr_out, sl_out, busy, done, err;

  usr_cmd_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .q_in(q_in), .s(s), .p_out(p_out), .sr_out(sr_out), .sl_out(sl_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Slice register driven by the sequencer
  logic [W-1:0] sreg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sreg <= '0;
    else begin
      case (s)
        2'b01:   sreg <= {sr_out, sreg[W-1:1]};
        2'b10:   sreg <= {sreg[W-2:0], sl_out};
        2'b11:   sreg <= p_out;
        default: sreg <= sreg;
      endcase
    end
  end
  assign q_in = sreg;

  typedef struct {
    logic [1:0] s;
    logic [3:0] p;
    logic       done;
    logic       err;
    logic [2:0] op;
    logic       fill;
    int         r;
  } exp_t;

  exp_t q[$];
  int   mreg = 0;
  bit   accepted;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Expected activity of one accepted command, from the command rules alone
  task automatic build(input int op, input int cnt, input int data, input int fill);
    exp_t e;
    int k;
    int v;
    v = mreg;
    k = 0;
    e.op = op[2:0];
    e.fill = fill[0];
    e.done = 1'b0;
    e.err = 1'b0;
    e.p = 4'd0;
    e.s = 2'd0;
    e.r = 0;
    if (op == 1 || op == 6) begin
      k = 1;
      e.s = 2'b11;
      e.p = (op == 1) ? data[3:0] : 4'd0;
      v = (op == 1) ? data : 0;
    end else if (op >= 2 && op <= 5) begin
      k = cnt;
      e.s = (op == 2 || op == 4) ? 2'b01 : 2'b10;
      for (int i = 0; i < cnt; i++) begin
        case (op)
          2: v = (v / 2) + (fill * 8);
          3: v = ((v * 2) % 16) + fill;
          4: v = (v / 2) + ((v % 2) * 8);
          default: v = ((v * 2) % 16) + (v / 8);
        endcase
      end
    end
    for (int i = 0; i < k; i++) q.push_back(e);
    e.s = 2'b00;
    e.p = 4'd0;
    e.done = 1'b1;
    e.err = (op == 7);
    e.r = v;
    q.push_back(e);
    mreg = v;
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    accepted = 1'b0;
    if (q.size() == 0) begin
      if (cmd_valid && !rst) begin
        accepted = 1'b1;
        build(int'(cmd_op), int'(cmd_cnt), int'(cmd_data), int'(cmd_fill));
      end
    end else begin
      void'(q.pop_front());
    end
    @(negedge clk);
    chk("cmd_ready", cmd_ready, q.size() == 0);
    if (q.size() == 0) begin
      chk("idle_s", s, 2'b00);
      chk("idle_p", p_out, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);
      chk("idle_serial", {sr_out, sl_out}, 0);
    end else begin
      e = q[0];
      chk("s", s, e.s);
      chk("p_out", p_out, e.p);
      chk("busy", busy, 1);
      chk("done", done, e.done);
      chk("err", err, e.err);
      if (e.s == 2'b01 || e.s == 2'b10) begin
        case (e.op)
          3'd2, 3'd3: chk("fill_serial", {sr_out, sl_out}, {e.fill, e.fill});
          3'd4:       chk("ror_sr", sr_out, sreg[0]);
          default:    chk("rol_sl", sl_out, sreg[W-1]);
        endcase
      end
      if (e.done) chk("register", sreg, e.r);
    end
  endtask

  task automatic issue(input int op, input int cnt, input int data, input int fill, input bit keep);
    cmd_valid = 1'b1;
    cmd_op = op[2:0];
    cmd_cnt = cnt[3:0];
    cmd_data = data[W-1:0];
    cmd_fill = fill[0];
    accepted = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 0, 1);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_s", s, 0);
    chk("rst_outs", {p_out, busy, done, err, sr_out, sl_out}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);

    issue(1, 0, 4'b1011, 0, 0); drain();
    issue(2, 2, 0, 1, 0);       drain();
    issue(1, 0, 4'b1000, 0, 0); drain();
    issue(5, 5, 0, 0, 0);       drain();
    issue(3, 0, 0, 1, 0);       drain();
    issue(7, 3, 4'hF, 1, 0);    drain();
    issue(6, 0, 0, 0, 0);       drain();

    // Reset in the third shift cycle of a long SHR
    issue(1, 0, 4'b0110, 0, 0); drain();
    issue(2, 8, 0, 1, 0);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("abort_s", s, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_outs", {p_out, busy, done, err, sr_out, sl_out}, 0);
    chk("abort_reg", sreg, 0);
    q.delete();
    mreg = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_abort", cmd_ready, 1);
    repeat (3) cycle();

    // Valid held through a busy command with changed data
    issue(1, 0, 4'b0101, 0, 1);
    issue(1, 0, 4'b1010, 0, 0);
    drain();
    issue(4, 6, 0, 0, 1);
    issue(2, 15, 0, 0, 0);
    drain();

    for (int n = 0; n < 80; n++) begin
      int op, cnt;
      bit keep;
      op = $urandom_range(0, 7);
      cnt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      keep = ($urandom_range(0, 3) == 0);
      issue(op, cnt, $urandom_range(0, 15), $urandom_range(0, 1), keep);
      if (!keep) repeat ($urandom_range(0, 2)) cycle();
    end
    cmd_valid = 1'b0;
    drain();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
